// File: rtl/cm0_dap_jt_cdc_mask_bus.sv
// Four-phase CDC receiver: synchronises a level request into SWCLKTCK, captures a
// multi-bit payload through a per-bit AND mask gated by the synchronised request.
module cm0_dap_jt_cdc_mask_bus #(
    parameter int unsigned PRESENT     = 1,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             SWCLKTCK,
    input  logic             DPRESETn,
    input  logic             REQ_ASYNC,
    input  logic [WIDTH-1:0] DATA_ASYNC,
    input  logic             MASKEN,
    output logic             ACK,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             VALID,
    output logic             BUSY
);

    if (PRESENT != 0) begin : g_present
        typedef enum logic [0:0] {StIdle, StAckHi} state_e;

        state_e                 state_q;
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   req_sync;
        logic [WIDTH-1:0]       masked_data;
        logic                   ack_q;
        logic                   valid_q;
        logic [WIDTH-1:0]       dataout_q;

        always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
            if (!DPRESETn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
            end
        end

        assign req_sync = sync_q[SYNC_STAGES-1];

        // One AND per bit; each maps onto a dedicated glitch-free gate so the payload
        // is held at zero while the request is not yet synchronised.
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mask
            assign masked_data[i] = DATA_ASYNC[i] & req_sync;
        end

        always_ff @(posedge SWCLKTCK or negedge DPRESETn) begin
            if (!DPRESETn) begin
                state_q   <= StIdle;
                ack_q     <= 1'b0;
                valid_q   <= 1'b0;
                dataout_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        valid_q <= 1'b0;
                        // A pending request with MASKEN low simply waits here.
                        if (req_sync && MASKEN) begin
                            dataout_q <= masked_data;
                            valid_q   <= 1'b1;
                            ack_q     <= 1'b1;
                            state_q   <= StAckHi;
                        end
                    end
                    StAckHi: begin
                        valid_q <= 1'b0;
                        if (!req_sync) begin
                            ack_q   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end

        assign ACK     = ack_q;
        assign VALID   = valid_q;
        assign DATAOUT = dataout_q;
        assign BUSY    = (state_q == StAckHi);
    end else begin : g_absent
        logic unused_inputs;
        assign unused_inputs = ^{SWCLKTCK, DPRESETn, REQ_ASYNC, DATA_ASYNC, MASKEN};

        assign ACK     = 1'b0;
        assign VALID   = 1'b0;
        assign DATAOUT = '0;
        assign BUSY    = 1'b0;
    end

endmodule

// File: tb/tb_cm0_dap_jt_cdc_mask_bus.sv
// Bench for cm0_dap_jt_cdc_mask_bus: three instances (8b/2-stage, 64b/3-stage, absent)
// checked every cycle against a delay-line reference model plus directed checks.
module tb_cm0_dap_jt_cdc_mask_bus;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [63:0] data;
    logic        men;

    logic        a_ack, a_valid, a_busy;
    logic [7:0]  a_dout;
    logic        b_ack, b_valid, b_busy;
    logic [63:0] b_dout;
    logic        c_ack, c_valid, c_busy;
    logic [7:0]  c_dout;

    int n_tests;
    int n_fail;

    cm0_dap_jt_cdc_mask_bus #(.PRESENT(1), .WIDTH(8), .SYNC_STAGES(2)) u_dut_a (
        .SWCLKTCK   (clk),
        .DPRESETn   (rst_n),
        .REQ_ASYNC  (req),
        .DATA_ASYNC (data[7:0]),
        .MASKEN     (men),
        .ACK        (a_ack),
        .DATAOUT    (a_dout),
        .VALID      (a_valid),
        .BUSY       (a_busy)
    );

    cm0_dap_jt_cdc_mask_bus #(.PRESENT(1), .WIDTH(64), .SYNC_STAGES(3)) u_dut_b (
        .SWCLKTCK   (clk),
        .DPRESETn   (rst_n),
        .REQ_ASYNC  (req),
        .DATA_ASYNC (data),
        .MASKEN     (men),
        .ACK        (b_ack),
        .DATAOUT    (b_dout),
        .VALID      (b_valid),
        .BUSY       (b_busy)
    );

    cm0_dap_jt_cdc_mask_bus #(.PRESENT(0), .WIDTH(8), .SYNC_STAGES(2)) u_dut_c (
        .SWCLKTCK   (clk),
        .DPRESETn   (rst_n),
        .REQ_ASYNC  (req),
        .DATA_ASYNC (data[7:0]),
        .MASKEN     (men),
        .ACK        (c_ack),
        .DATAOUT    (c_dout),
        .VALID      (c_valid),
        .BUSY       (c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: hist[k] is REQ_ASYNC as seen k+1 edges ago; the request is
    // recognised S edges after it was first sampled.
    typedef struct packed {
        logic [7:0]  hist;
        logic        ack;
        logic        valid;
        logic        busy;
        logic [63:0] dout;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(model_t m, int s, logic r, logic [63:0] d, logic en);
        model_t n;
        logic   rs;
        n       = m;
        rs      = m.hist[s-1];
        n.valid = 1'b0;
        if (!m.busy) begin
            if (rs && en) begin
                n.dout  = d;
                n.valid = 1'b1;
                n.ack   = 1'b1;
                n.busy  = 1'b1;
            end
        end else if (!rs) begin
            n.ack  = 1'b0;
            n.busy = 1'b0;
        end
        n.hist = {m.hist[6:0], r};
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("a_ack", {63'd0, a_ack}, {63'd0, ma.ack});
        check_eq("a_valid", {63'd0, a_valid}, {63'd0, ma.valid});
        check_eq("a_busy", {63'd0, a_busy}, {63'd0, ma.busy});
        check_eq("a_dout", {56'd0, a_dout}, {56'd0, ma.dout[7:0]});
        check_eq("b_ack", {63'd0, b_ack}, {63'd0, mb.ack});
        check_eq("b_valid", {63'd0, b_valid}, {63'd0, mb.valid});
        check_eq("b_busy", {63'd0, b_busy}, {63'd0, mb.busy});
        check_eq("b_dout", b_dout, mb.dout);
        check_eq("c_zero", {53'd0, c_ack, c_valid, c_busy, c_dout}, 64'd0);
    endtask

    // Inputs change only at the negedge; models advance at the posedge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = step(ma, 2, req, data, men);
            mb = step(mb, 3, req, data, men);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int pulses;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 1'b0;
        data    = '0;
        men     = 1'b1;
        ma      = '0;
        mb      = '0;
        #1;
        check_all();
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // Basic transfer: capture at edge 3, ACK falls 3 edges after REQ falls.
        data = 64'hA5;
        req  = 1'b1;
        cycles(2);
        check_eq("basic_pre_valid", {63'd0, a_valid}, 64'd0);
        cycle();
        check_eq("basic_dout", {56'd0, a_dout}, 64'hA5);
        check_eq("basic_valid", {63'd0, a_valid}, 64'd1);
        check_eq("basic_ack", {63'd0, a_ack}, 64'd1);
        cycle();
        check_eq("basic_valid_fall", {63'd0, a_valid}, 64'd0);
        req = 1'b0;
        cycles(2);
        check_eq("basic_ack_hold", {63'd0, a_ack}, 64'd1);
        cycle();
        check_eq("basic_ack_fall", {63'd0, a_ack}, 64'd0);
        check_eq("basic_busy_fall", {63'd0, a_busy}, 64'd0);
        cycles(2);

        // Mask hold-off.
        men  = 1'b0;
        data = 64'h3C;
        req  = 1'b1;
        cycles(10);
        check_eq("holdoff_ack", {63'd0, a_ack}, 64'd0);
        check_eq("holdoff_dout", {56'd0, a_dout}, 64'hA5);
        men = 1'b1;
        cycle();
        check_eq("holdoff_cap", {56'd0, a_dout}, 64'h3C);
        check_eq("holdoff_valid", {63'd0, a_valid}, 64'd1);
        req = 1'b0;
        cycles(5);

        // Back-to-back four-phase transfers.
        pulses = 0;
        for (int k = 0; k < 2; k++) begin
            data = (k == 0) ? 64'h01 : 64'hFE;
            req  = 1'b1;
            for (int t = 0; t < 10 && !a_ack; t++) begin
                cycle();
                if (a_valid) begin
                    pulses++;
                    check_eq("b2b_dout", {56'd0, a_dout}, data & 64'hFF);
                end
            end
            check_eq("b2b_ack_rise", {63'd0, a_ack}, 64'd1);
            req = 1'b0;
            for (int t = 0; t < 10 && a_ack; t++) begin
                cycle();
                if (a_valid) pulses++;
            end
            check_eq("b2b_ack_fall", {63'd0, a_ack}, 64'd0);
        end
        cycles(3);
        check_eq("b2b_pulses", 64'(pulses), 64'd2);

        // Reset mid-handshake, then recapture with REQ still high.
        data = 64'h5A;
        req  = 1'b1;
        cycles(4);
        check_eq("rst_pre_busy", {63'd0, a_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        ma = '0;
        mb = '0;
        check_all();
        check_eq("rst_async", {53'd0, a_ack, a_valid, a_busy, a_dout}, 64'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check_eq("rst_recap_valid", {63'd0, a_valid}, 64'd1);
        check_eq("rst_recap_dout", {56'd0, a_dout}, 64'h5A);
        req = 1'b0;
        cycles(5);

        // Latency sweep on the 3-stage, 64-bit instance.
        data = 64'hDEADBEEF_CAFEF00D;
        req  = 1'b1;
        cycles(3);
        check_eq("lat_pre_valid", {63'd0, b_valid}, 64'd0);
        cycle();
        check_eq("lat_valid", {63'd0, b_valid}, 64'd1);
        check_eq("lat_dout", b_dout, 64'hDEADBEEF_CAFEF00D);
        req = 1'b0;
        cycles(3);
        check_eq("lat_ack_hold", {63'd0, b_ack}, 64'd1);
        cycle();
        check_eq("lat_ack_fall", {63'd0, b_ack}, 64'd0);
        cycles(2);

        // Random traffic, including early REQ drops and MASKEN toggling.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            if (!req) data = {$urandom(), $urandom()};
            men = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
